// File: rtl/dm_access_ctrl.sv
// Load/store sequencer between the MEM stage and a word-organised data memory.
// Splits word-crossing accesses into two aligned word accesses, merges and extends load data.
module dm_access_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [31:0]      req_addr,
    input  logic [2:0]       req_type,
    input  logic [31:0]      req_wdata,
    output logic             rsp_valid,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic [29:0]      mem_addr,
    output logic             mem_we,
    output logic [3:0]       mem_be,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] split_cnt
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

    state_t state, state_nxt;

    logic             we_q;
    logic [31:0]      addr_q;
    logic [2:0]       type_q;
    logic [31:0]      wdata_q;
    logic             err_q;
    logic [31:0]      lo_q;
    logic [31:0]      hi_q;
    logic [CNT_W-1:0] cnt_q;
    logic [29:0]      mem_addr_q;
    logic [31:0]      mem_wdata_q;

    logic [1:0]  off;
    logic [3:0]  size;
    logic [3:0]  mask;
    logic        is_signed;
    logic        span2;
    logic [7:0]  be_wide;
    logic [63:0] wd_wide;
    logic [63:0] rd_wide;
    logic [31:0] raw;
    logic [31:0] ld_data;

    // Access geometry, all derived from the captured request.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        size      = 4'd1;
        mask      = 4'h1;
        is_signed = (type_q == 3'b001) || (type_q == 3'b011);
        case (type_q)
            3'b000:         begin size = 4'd4; mask = 4'hF; end
            3'b001, 3'b010: begin size = 4'd2; mask = 4'h3; end
            default:        begin size = 4'd1; mask = 4'h1; end
        endcase
    end

    assign off     = addr_q[1:0];
    assign span2   = ({2'b00, off} + size) > 4'd4;
    assign be_wide = {4'h0, mask} << off;
    assign wd_wide = {32'h0, wdata_q} << {off, 3'b000};
    assign rd_wide = {hi_q, lo_q} >> {off, 3'b000};
    assign raw     = rd_wide[31:0];

    always_comb begin
        ld_data = raw;
        case (size)
            4'd2:    ld_data = is_signed ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
            4'd1:    ld_data = is_signed ? {{24{raw[7]}}, raw[7:0]} : {24'h0, raw[7:0]};
            default: ld_data = raw;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = (req_type <= 3'b100) ? ACC0 : DONE;
            ACC0:    state_nxt = span2 ? ACC1 : DONE;
            ACC1:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic; memory strobes are decoded from state so reset drops them immediately.
    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == DONE);
        rsp_err   = (state == DONE) && err_q;
        rsp_rdata = (state == DONE && !err_q && !we_q) ? ld_data : 32'h0;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        case (state)
            ACC0: begin
                mem_addr  = addr_q[31:2];
                mem_be    = be_wide[3:0];
                mem_wdata = wd_wide[31:0];
                mem_we    = we_q;
            end
            ACC1: begin
                mem_addr  = addr_q[31:2] + 30'd1;
                mem_be    = be_wide[7:4];
                mem_wdata = wd_wide[63:32];
                mem_we    = we_q;
            end
            default: ;
        endcase
    end

    // Request capture, load-data merge and split counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            type_q      <= 3'b000;
            wdata_q     <= 32'h0;
            err_q       <= 1'b0;
            lo_q        <= 32'h0;
            hi_q        <= 32'h0;
            cnt_q       <= '0;
            mem_addr_q  <= 30'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            mem_addr_q  <= mem_addr;
            mem_wdata_q <= mem_wdata;
            case (state)
                IDLE: if (req_valid) begin
                    we_q    <= req_we;
                    addr_q  <= req_addr;
                    type_q  <= req_type;
                    wdata_q <= req_wdata;
                    err_q   <= (req_type > 3'b100);
                    lo_q    <= 32'h0;
                    hi_q    <= 32'h0;
                end
                ACC0: begin
                    if (!we_q) lo_q <= mem_rdata;
                    if (span2 && cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
                end
                ACC1: if (!we_q) hi_q <= mem_rdata;
                default: ;
            endcase
        end
    end

    assign split_cnt = cnt_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: a byte-addressed reference memory predicts load data,
// memory-port lanes, latency and split count; a word memory in the bench answers the DUT.
module tb_dm_access_ctrl;

    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_we = 1'b0;
    logic [31:0]      req_addr = 32'h0;
    logic [2:0]       req_type = 3'b000;
    logic [31:0]      req_wdata = 32'h0;
    logic             rsp_valid;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;
    logic [29:0]      mem_addr;
    logic             mem_we;
    logic [3:0]       mem_be;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata = 32'h0;
    logic [CNT_W-1:0] split_cnt;

    dm_access_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_type(req_type), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .split_cnt(split_cnt)
    );

    always #5 clk = ~clk;

    logic [31:0] mem_words [logic [29:0]];
    logic [7:0]  ref_bytes [logic [31:0]];
    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [29:0] a);
        return mem_words.exists(a) ? mem_words[a] : 32'h0;
    endfunction

    function automatic logic [7:0] rb(input logic [31:0] a);
        return ref_bytes.exists(a) ? ref_bytes[a] : 8'h0;
    endfunction

    function automatic int sz(input logic [2:0] t);
        case (t)
            3'b000:         return 4;
            3'b001, 3'b010: return 2;
            3'b011, 3'b100: return 1;
            default:        return 0;
        endcase
    endfunction

    // Bench memory: sample strobes mid-cycle, commit on the next rising edge.
    logic        pend_we = 1'b0;
    logic [29:0] pend_addr;
    logic [3:0]  pend_be;
    logic [31:0] pend_wd;

    always @(negedge clk) begin
        #2;
        pend_we   = mem_we;
        pend_addr = mem_addr;
        pend_be   = mem_be;
        pend_wd   = mem_wdata;
        mem_rdata = rd_word(mem_addr);
    end

    always @(posedge clk) begin : mem_commit
        logic [31:0] w;
        if (pend_we) begin
            w = rd_word(pend_addr);
            for (int l = 0; l < 4; l++)
                if (pend_be[l]) w[8*l +: 8] = pend_wd[8*l +: 8];
            mem_words[pend_addr] = w;
        end
        pend_we = 1'b0;
    end

    task automatic preload(input logic [29:0] wa, input logic [31:0] val);
        mem_words[wa] = val;
        for (int i = 0; i < 4; i++) ref_bytes[{wa, 2'b00} + 32'(i)] = val[8*i +: 8];
    endtask

    // Issue one request from an IDLE negedge and check every cycle until the response pulse.
    task automatic run_req(input logic we, input logic [31:0] addr, input logic [2:0] t,
                           input logic [31:0] wdata, output logic [31:0] rdata_o, output int lat_o);
        int          s;
        bit          legal;
        bit          span;
        int          exp_lat;
        logic [31:0] exp_rd;
        logic [29:0] exp_wa [2];
        logic [3:0]  exp_be [2];
        logic [31:0] exp_wd [2];
        logic [31:0] lane_mask;
        logic [31:0] b;
        int          k;

        s       = sz(t);
        legal   = (t <= 3'b100);
        span    = legal && (int'(addr[1:0]) + s > 4);
        exp_lat = !legal ? 1 : (span ? 3 : 2);
        exp_rd  = 32'h0;
        for (int a = 0; a < 2; a++) begin
            exp_wa[a] = addr[31:2] + 30'(a);
            exp_be[a] = 4'h0;
            exp_wd[a] = 32'h0;
        end
        for (int i = 0; i < s; i++) begin
            b = addr + 32'(i);
            k = (b[31:2] == addr[31:2]) ? 0 : 1;
            exp_be[k][b[1:0]] = 1'b1;
            exp_wd[k][8*b[1:0] +: 8] = wdata[8*i +: 8];
            if (legal && !we) exp_rd[8*i +: 8] = rb(b);
        end
        if (legal && !we && (t == 3'b001) && exp_rd[15]) exp_rd[31:16] = 16'hFFFF;
        if (legal && !we && (t == 3'b011) && exp_rd[7])  exp_rd[31:8]  = 24'hFFFFFF;

        check("ready_idle", req_ready, 1'b1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_type  = t;
        req_wdata = wdata;
        @(posedge clk);
        if (legal && we)
            for (int i = 0; i < s; i++) ref_bytes[addr + 32'(i)] = wdata[8*i +: 8];
        if (span && exp_cnt < CNT_MAX) exp_cnt++;

        rdata_o = 32'hDEAD_DEAD;
        lat_o   = 0;
        for (int cyc = 1; cyc <= exp_lat; cyc++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_we    = 1'($urandom);
            req_addr  = $urandom;
            req_type  = 3'($urandom);
            req_wdata = $urandom;
            if (rsp_valid && lat_o == 0) lat_o = cyc;
            check("ready_busy", req_ready, 1'b0);
            check("rsp_valid", rsp_valid, 32'(cyc == exp_lat));
            if (cyc < exp_lat) begin
                lane_mask = {{8{exp_be[cyc-1][3]}}, {8{exp_be[cyc-1][2]}},
                             {8{exp_be[cyc-1][1]}}, {8{exp_be[cyc-1][0]}}};
                check("mem_we", mem_we, we);
                check("mem_be", mem_be, exp_be[cyc-1]);
                check("mem_addr", mem_addr, exp_wa[cyc-1]);
                if (we) check("mem_wdata", mem_wdata & lane_mask, exp_wd[cyc-1]);
            end else begin
                rdata_o = rsp_rdata;
                check("rsp_err", rsp_err, !legal);
                check("rsp_rdata", rsp_rdata, exp_rd);
                check("split_cnt", split_cnt, exp_cnt);
                check("mem_we_done", mem_we, 1'b0);
                check("mem_be_done", mem_be, 4'h0);
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        check("rsp_pulse_end", rsp_valid, 1'b0);
    endtask

    logic [31:0] rd;
    int          lat;
    logic [31:0] ra;
    logic [31:0] wexp;

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", req_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_be", mem_be, 4'h0);
        check("rst_mem_addr", mem_addr, 30'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_split_cnt", split_cnt, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        preload(30'd0, 32'h44332211);
        preload(30'd1, 32'h88776655);

        run_req(1'b0, 32'h3, 3'b000, 32'h0, rd, lat);
        check("t1_rdata", rd, 32'h77665544);
        check("t1_lat", lat, 3);
        check("t1_cnt", split_cnt, 1);

        run_req(1'b0, 32'h7, 3'b011, 32'h0, rd, lat);
        check("t2_byte", rd, 32'hFFFFFF88);
        check("t2_lat", lat, 2);
        run_req(1'b0, 32'h7, 3'b100, 32'h0, rd, lat);
        check("t2_ubyte", rd, 32'h00000088);
        check("t2_cnt", split_cnt, 1);

        run_req(1'b1, 32'h7, 3'b001, 32'h0000BEEF, rd, lat);
        check("t3_w1", rd_word(30'd1), 32'hEF776655);
        check("t3_w2", rd_word(30'd2), 32'h000000BE);
        run_req(1'b0, 32'h7, 3'b001, 32'h0, rd, lat);
        check("t3_reload", rd, 32'hFFFFBEEF);

        run_req(1'b1, 32'hFFFFFFFE, 3'b000, 32'hCAFEF00D, rd, lat);
        check("t4_top", rd_word(30'h3FFFFFFF), 32'hF00D0000);
        run_req(1'b0, 32'h0, 3'b000, 32'h0, rd, lat);
        check("t4_w0", rd, 32'h4433CAFE);

        run_req(1'b0, 32'h4, 3'b110, 32'h0, rd, lat);
        check("t5_lat", lat, 1);
        check("t5_rdata", rd, 32'h0);

        for (int n = 0; n < 150; n++) begin
            ra = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7))
                                             : 32'($urandom_range(0, 63));
            run_req(1'($urandom), ra, 3'($urandom_range(0, 7)), $urandom, rd, lat);
        end
        check("cnt_saturated", split_cnt, CNT_MAX);

        // Reset during the second half of a spanning store.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h207; req_type = 3'b001; req_wdata = 32'h1234;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("t6_acc1_we", mem_we, 1'b1);
        rst = 1'b1;
        #1;
        check("t6_we_drop", mem_we, 1'b0);
        check("t6_cnt", split_cnt, 32'h0);
        check("t6_ready", req_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t6_no_rsp", rsp_valid, 1'b0);
        end
        check("t6_ready_after", req_ready, 1'b1);

        for (int n = 0; n < 20; n++) begin
            ra = 32'($urandom_range(0, 63));
            run_req(1'($urandom), ra, 3'($urandom_range(0, 4)), $urandom, rd, lat);
        end

        for (int w = 0; w < 16; w++) begin
            for (int i = 0; i < 4; i++) wexp[8*i +: 8] = rb(32'(4*w + i));
            check("final_mem", rd_word(30'(w)), wexp);
        end
        for (int w = 2; w < 4; w++) begin
            for (int i = 0; i < 4; i++) wexp[8*i +: 8] = rb(32'hFFFFFFF0 + 32'(4*w + i));
            check("final_mem_top", rd_word(30'h3FFFFFFC + 30'(w)), wexp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
